// File: rtl/fifo_ram_mp.sv
// fifo_ram_mp: circular FIFO over a register file with multi-lane enqueue/dequeue,
// random-access read/write ports, flush and asynchronous clear.
module fifo_ram_mp #(
  parameter  int ENTRY_WIDTH   = 32,
  parameter  int N_ENTRIES     = 8,
  parameter  int N_ENQ_PORTS   = 2,
  parameter  int N_DEQ_PORTS   = 2,
  parameter  int N_READ_PORTS  = 2,
  parameter  int N_WRITE_PORTS = 2,
  localparam int PTR_WIDTH     = $clog2(N_ENTRIES),
  localparam int CTR_WIDTH     = PTR_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst_aL,
  input  logic [N_ENQ_PORTS-1:0] enq_valid,
  output logic [N_ENQ_PORTS-1:0] enq_ready,
  input  logic [ENTRY_WIDTH-1:0] enq_data [N_ENQ_PORTS],
  output logic [PTR_WIDTH-1:0]   enq_addr [N_ENQ_PORTS],
  input  logic [N_DEQ_PORTS-1:0] deq_ready,
  output logic [N_DEQ_PORTS-1:0] deq_valid,
  output logic [ENTRY_WIDTH-1:0] deq_data [N_DEQ_PORTS],
  output logic [PTR_WIDTH-1:0]   deq_addr [N_DEQ_PORTS],
  input  logic [PTR_WIDTH-1:0]   rd_addr  [N_READ_PORTS],
  output logic [ENTRY_WIDTH-1:0] rd_data  [N_READ_PORTS],
  input  logic [N_WRITE_PORTS-1:0] wr_en,
  input  logic [PTR_WIDTH-1:0]   wr_addr  [N_WRITE_PORTS],
  input  logic [ENTRY_WIDTH-1:0] wr_data  [N_WRITE_PORTS],
  input  logic                   flush,
  output logic [CTR_WIDTH-1:0]   count,
  output logic                   full,
  output logic                   empty
);

  localparam logic [CTR_WIDTH-1:0] DEPTH_C = CTR_WIDTH'(N_ENTRIES);
  localparam logic [CTR_WIDTH-1:0] ZERO_C  = {CTR_WIDTH{1'b0}};
  localparam logic [CTR_WIDTH-1:0] ONE_C   = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

  logic [CTR_WIDTH-1:0]   head_r;
  logic [CTR_WIDTH-1:0]   tail_r;
  logic [ENTRY_WIDTH-1:0] mem_r [N_ENTRIES];
  logic [CTR_WIDTH-1:0]   count_s;
  logic [CTR_WIDTH-1:0]   free_s;
  logic [CTR_WIDTH-1:0]   n_enq_s;
  logic [CTR_WIDTH-1:0]   n_deq_s;
  logic [N_ENQ_PORTS-1:0] enq_acc_s;
  logic [N_DEQ_PORTS-1:0] deq_acc_s;

  // Occupancy is the wrapped pointer difference; one extra bit separates full from empty
  assign count_s = tail_r - head_r;
  assign free_s  = DEPTH_C - count_s;
  assign count   = count_s;
  assign empty   = (count_s == ZERO_C);
  assign full    = (count_s == DEPTH_C);

  // Lane handshakes and addresses come from registered pointers only, never from flush
  always_comb begin
    for (int i = 0; i < N_ENQ_PORTS; i++) begin
      enq_ready[i] = (free_s > CTR_WIDTH'(i));
      enq_addr[i]  = tail_r[PTR_WIDTH-1:0] + PTR_WIDTH'(i);
    end
    for (int j = 0; j < N_DEQ_PORTS; j++) begin
      deq_valid[j] = (count_s > CTR_WIDTH'(j));
      deq_addr[j]  = head_r[PTR_WIDTH-1:0] + PTR_WIDTH'(j);
      deq_data[j]  = mem_r[head_r[PTR_WIDTH-1:0] + PTR_WIDTH'(j)];
    end
  end

  // Prefix acceptance: a lane only counts if every lower lane also handshook
  always_comb begin
    logic run_s;
    enq_acc_s = {N_ENQ_PORTS{1'b0}};
    deq_acc_s = {N_DEQ_PORTS{1'b0}};
    n_enq_s   = ZERO_C;
    n_deq_s   = ZERO_C;
    run_s     = 1'b1;
    for (int i = 0; i < N_ENQ_PORTS; i++) begin
      run_s        = run_s & enq_valid[i] & enq_ready[i];
      enq_acc_s[i] = run_s;
      if (run_s) n_enq_s = n_enq_s + ONE_C;
      else       n_enq_s = n_enq_s;
    end
    run_s = 1'b1;
    for (int j = 0; j < N_DEQ_PORTS; j++) begin
      run_s        = run_s & deq_ready[j] & deq_valid[j];
      deq_acc_s[j] = run_s;
      if (run_s) n_deq_s = n_deq_s + ONE_C;
      else       n_deq_s = n_deq_s;
    end
  end

  // Random-access reads see registered contents only
  always_comb begin
    for (int r = 0; r < N_READ_PORTS; r++) begin
      rd_data[r] = mem_r[rd_addr[r]];
    end
  end

  // Head/tail pointers
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      head_r <= ZERO_C;
      tail_r <= ZERO_C;
    end else if (flush) begin
      head_r <= ZERO_C;
      tail_r <= ZERO_C;
    end else begin
      tail_r <= tail_r + n_enq_s;
      head_r <= head_r + n_deq_s;
    end
  end

  // Storage: later assignments win, so ports go in ascending order and enqueues last
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int e = 0; e < N_ENTRIES; e++) mem_r[e] <= {ENTRY_WIDTH{1'b0}};
    end else if (!flush) begin
      for (int p = 0; p < N_WRITE_PORTS; p++) begin
        if (wr_en[p]) mem_r[wr_addr[p]] <= wr_data[p];
      end
      for (int i = 0; i < N_ENQ_PORTS; i++) begin
        if (enq_acc_s[i]) mem_r[tail_r[PTR_WIDTH-1:0] + PTR_WIDTH'(i)] <= enq_data[i];
      end
    end
  end

endmodule

// File: tb/tb_fifo_ram_mp.sv
// tb_fifo_ram_mp: directed scenarios plus randomized traffic checked against a
// queue-level reference model (head index, occupancy and an entry array).
module tb_fifo_ram_mp;

  logic        clk = 1'b0;
  logic        rst_aL;
  logic        flush;
  logic [1:0]  enq_valid, enq_ready, deq_ready, deq_valid, wr_en;
  logic [31:0] enq_data [2];
  logic [31:0] deq_data [2];
  logic [31:0] rd_data  [2];
  logic [31:0] wr_data  [2];
  logic [2:0]  enq_addr [2];
  logic [2:0]  deq_addr [2];
  logic [2:0]  rd_addr  [2];
  logic [2:0]  wr_addr  [2];
  logic [3:0]  count;
  logic        full, empty;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [8];
  int          m_head;
  int          m_count;
  logic [31:0] got_q [$];
  logic [31:0] snap  [8];

  fifo_ram_mp dut (
    .clk(clk), .rst_aL(rst_aL),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data), .enq_addr(enq_addr),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_data(deq_data), .deq_addr(deq_addr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int e = 0; e < 8; e++) m_mem[e] = 32'h0;
    m_head  = 0;
    m_count = 0;
  endfunction

  // Queue-level rules: prefix acceptance, ports then enqueues, flush discards everything
  function automatic void m_step();
    int ne, nd;
    bit run;
    if (flush) begin
      m_head  = 0;
      m_count = 0;
      return;
    end
    ne = 0; nd = 0; run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run = run && enq_valid[i] && (8 - m_count > i);
      if (run) ne++;
    end
    run = 1'b1;
    for (int j = 0; j < 2; j++) begin
      run = run && deq_ready[j] && (m_count > j);
      if (run) nd++;
    end
    for (int p = 0; p < 2; p++) if (wr_en[p]) m_mem[wr_addr[p]] = wr_data[p];
    for (int i = 0; i < ne; i++) m_mem[(m_head + m_count + i) % 8] = enq_data[i];
    m_head  = (m_head + nd) % 8;
    m_count = m_count + ne - nd;
  endfunction

  task automatic compare_all();
    check("count", count, m_count);
    check("empty", empty, m_count == 0);
    check("full", full, m_count == 8);
    for (int i = 0; i < 2; i++) begin
      check("enq_ready", enq_ready[i], (8 - m_count) > i);
      check("enq_addr", enq_addr[i], (m_head + m_count + i) % 8);
      check("deq_valid", deq_valid[i], m_count > i);
      check("deq_addr", deq_addr[i], (m_head + i) % 8);
      check("deq_data", deq_data[i], m_mem[(m_head + i) % 8]);
      check("rd_data", rd_data[i], m_mem[rd_addr[i]]);
    end
  endtask

  task automatic clear_in();
    flush = 1'b0;
    enq_valid = 2'b00;
    deq_ready = 2'b00;
    wr_en = 2'b00;
    for (int i = 0; i < 2; i++) begin
      enq_data[i] = $urandom;
      wr_data[i]  = $urandom;
      wr_addr[i]  = 3'($urandom_range(0, 7));
      rd_addr[i]  = 3'($urandom_range(0, 7));
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge
  task automatic cycle();
    #1 compare_all();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst_aL = 1'b0;
    m_reset();
    #1 compare_all();
    @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    rst_aL = 1'b1;
  endtask

  initial begin
    clear_in();
    rst_aL = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_ready", enq_ready, 2'b11);
    rst_aL = 1'b1;

    // Dual enqueue then single
    enq_valid = 2'b11; enq_data[0] = 32'hA; enq_data[1] = 32'hB; cycle();
    clear_in(); enq_valid = 2'b01; enq_data[0] = 32'hC; cycle();
    clear_in(); #1;
    check("dual_count", count, 3);
    check("dual_d0", deq_data[0], 32'hA);
    check("dual_d1", deq_data[1], 32'hB);
    check("dual_addr", enq_addr[0], 3);

    // Fill to 7, then prefix behaviour near full
    enq_valid = 2'b11; cycle();
    clear_in(); enq_valid = 2'b11; cycle();
    clear_in(); enq_valid = 2'b11; #1;
    check("fill_ready", enq_ready, 2'b01);
    cycle();
    clear_in(); #1;
    check("fill_full", full, 1'b1);
    check("fill_ready0", enq_ready, 2'b00);
    deq_ready = 2'b11; cycle();
    clear_in(); enq_valid = 2'b10; cycle();
    clear_in(); #1;
    check("prefix_drop", count, 6);

    // Full with simultaneous traffic
    enq_valid = 2'b11; cycle();
    clear_in(); #1;
    check("full_again", full, 1'b1);
    enq_valid = 2'b11; deq_ready = 2'b11; cycle();
    clear_in(); #1;
    check("full_traffic", count, 6);

    // Streaming across pointer wrap
    flush = 1'b1; cycle();
    clear_in(); enq_valid = 2'b11; enq_data[0] = 32'd0; enq_data[1] = 32'd1; cycle();
    for (int c = 0; c < 20; c++) begin
      clear_in();
      enq_valid = 2'b11; deq_ready = 2'b11;
      enq_data[0] = 32'(2 * c + 2); enq_data[1] = 32'(2 * c + 3);
      #1;
      got_q.push_back(deq_data[0]);
      got_q.push_back(deq_data[1]);
      check("stream_count", count, 2);
      cycle();
    end
    check("stream_len", got_q.size(), 40);
    for (int k = 0; k < 40 && k < got_q.size(); k++) check("stream_order", got_q[k], k);

    // Write collisions on entry 2
    clear_in(); flush = 1'b1; cycle();
    clear_in(); enq_valid = 2'b11; cycle();
    clear_in(); enq_valid = 2'b01; enq_data[0] = 32'h55;
    wr_en = 2'b11; wr_addr[0] = 3'd2; wr_addr[1] = 3'd2;
    wr_data[0] = 32'h111; wr_data[1] = 32'h222; cycle();
    clear_in(); rd_addr[0] = 3'd2; #1;
    check("coll_enq", rd_data[0], 32'h55);
    wr_en = 2'b11; wr_addr[0] = 3'd2; wr_addr[1] = 3'd2;
    wr_data[0] = 32'h111; wr_data[1] = 32'h222; cycle();
    clear_in(); rd_addr[0] = 3'd2; #1;
    check("coll_port", rd_data[0], 32'h222);

    // Flush with traffic offered, then asynchronous reset between edges
    enq_valid = 2'b11; cycle();
    clear_in(); #1;
    check("pre_flush", count, 5);
    for (int e = 0; e < 8; e++) snap[e] = m_mem[e];
    flush = 1'b1; enq_valid = 2'b11; deq_ready = 2'b11;
    wr_en = 2'b11; wr_addr[0] = 3'd0; wr_addr[1] = 3'd1;
    wr_data[0] = 32'hDEAD; wr_data[1] = 32'hBEEF; cycle();
    clear_in(); rd_addr[0] = 3'd0; rd_addr[1] = 3'd1; #1;
    check("flush_count", count, 0);
    check("flush_keep0", rd_data[0], snap[0]);
    check("flush_keep1", rd_data[1], snap[1]);
    rd_addr[0] = 3'd2; #1;
    check("flush_keep2", rd_data[0], snap[2]);
    @(negedge clk);
    rd_addr[0] = 3'd2;
    fork
      async_reset();
      begin
        #3 check("areset_empty", empty, 1'b1);
        check("areset_rd", rd_data[0], 32'h0);
      end
    join

    // Randomized traffic with occasional flush and mid-cycle reset
    for (int n = 0; n < 400; n++) begin
      clear_in();
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end else begin
        enq_valid = 2'($urandom);
        deq_ready = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
        if ($urandom_range(0, 3) == 0) deq_ready = 2'b11;
        wr_en = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
        flush = ($urandom_range(0, 31) == 0);
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
